ping_sequencer: RTL and testbench
=================================

// Module: ping_sequencer
// PURPOSE
//  Pulse-repetition controller placed directly upstream of the chirp transmitter. It drives enTx and
//  ends each chirp on overTx. After each chirp it opens an rx_gate listening window, then holds
//  until the pulse-repetition interval (PRI) expires. It emits num_pings pings, or runs
//  continuously when num_pings==0.
// PARAMETERS
//  CNT_W        20      width of PRI/listen/timeout counters
//  PRI_CYCLES   100000  cycles between successive enTx rising edges (1 ms @ 100 MHz)
//  LISTEN_CYCLES 40000  cycles rx_gate is high after each chirp
//  TX_TIMEOUT   1024    max cycles in TX waiting for overTx before error abort
// PORTS
//  clk_100      in   1      system clock, 100 MHz
//  rst          in   1      synchronous, active-high reset
//  start        in   1      1-cycle request to begin a sequence (ignored while busy)
//  abort        in   1      level/pulse; stops sequence immediately
//  num_pings    in   8      pings per sequence, latched on start; 0 = continuous
//  enTx         out  1      transmitter enable, high for the whole chirp
//  overTx       in   1      1-cycle chirp-complete strobe from transmitter
//  rx_gate      out  1      receive window enable
//  busy         out  1      high in any state other than IDLE
//  ping_cnt     out  8      pings completed in current sequence (wraps 255->0 in continuous)
//  done         out  1      1-cycle pulse on normal sequence completion
//  err_timeout  out  1      sticky; set on TX timeout, cleared on next accepted start
//  pri_overrun  out  1      sticky; LISTEN ended after PRI expiry, cleared on next accepted start
// BEHAVIOUR
//  Reset: state=IDLE; enTx=0, rx_gate=0, busy=0, ping_cnt=0, done=0, err_timeout=0, pri_overrun=0.
//  All outputs are registered. Counters are CNT_W wide and saturate, never wrap.
//  Parameter rule: PRI_CYCLES > TX_TIMEOUT+LISTEN_CYCLES+2 recommended; violation is flagged only.
//  States: IDLE -> TX -> LISTEN -> WAIT -> TX ... ; any state -> IDLE on abort/timeout/completion.
//  IDLE: start sampled high at cycle N -> latch num_pings, clear ping_cnt/errors,
//        enTx=1 and busy=1 at N+1; pri_cnt=0 on that cycle.
//  TX: enTx=1; tx_cnt counts from 0. overTx sampled high -> next cycle enTx=0, rx_gate=1,
//      ping_cnt+1, state LISTEN. tx_cnt==TX_TIMEOUT-1 with no overTx -> next cycle IDLE,
//      enTx=0, err_timeout=1, no done. overTx and timeout in the same cycle: overTx wins.
//  LISTEN: rx_gate high exactly LISTEN_CYCLES cycles. At the end:
//      if ping_cnt==latched num_pings (num_pings!=0) -> rx_gate=0, done=1 for 1 cycle, IDLE
//      (no trailing PRI wait); else -> WAIT.
//  WAIT: enTx rises again when pri_cnt reaches PRI_CYCLES. Successive enTx rising edges are
//      exactly PRI_CYCLES apart. If pri_cnt already >= PRI_CYCLES-1 when LISTEN ends ->
//      pri_overrun=1 and TX starts next cycle.
//  pri_cnt runs from each enTx rise and saturates at its max.
//  abort high in any non-IDLE state -> next cycle IDLE with enTx=0, rx_gate=0, busy=0;
//      no done; ping_cnt holds. abort has priority over start, overTx and timeout.
//  start while busy: ignored. overTx outside TX: ignored.
//  rst mid-sequence: all outputs return to reset values on the next edge.
// TESTING (bench models transmitter: overTx pulses 513 cycles after enTx rises, unless disabled)
//  1. num_pings=3, start -> 3 enTx pulses of 513 cycles, rises spaced 100000 cycles apart;
//     rx_gate high 40000 cycles after each; done once; ping_cnt=3; busy low after done.
//  2. num_pings=0, run 5 PRIs, then abort in WAIT -> enTx/rx_gate/busy low next cycle;
//     ping_cnt=5; no done.
//  3. Transmitter model never asserts overTx -> enTx high exactly 1024 cycles, err_timeout=1,
//     IDLE; next start clears err_timeout.
//  4. start asserted during LISTEN, and overTx injected in WAIT -> neither changes state,
//     timing or ping_cnt.
//  5. abort and overTx in the same TX cycle -> IDLE, ping_cnt unchanged, rx_gate never rises.
//  6. Override PRI_CYCLES=600, LISTEN_CYCLES=200 -> pri_overrun=1; next TX starts the
//     cycle after LISTEN ends.

Source files
------------

// File: rtl/ping_sequencer.sv
// rtl/ping_sequencer.sv - pulse-repetition controller driving the chirp transmitter and rx window
module ping_sequencer #(
  parameter int CNT_W         = 20,
  parameter int PRI_CYCLES    = 100000,
  parameter int LISTEN_CYCLES = 40000,
  parameter int TX_TIMEOUT    = 1024
) (
  input  logic       clk_100,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  input  logic [7:0] num_pings,
  output logic       enTx,
  input  logic       overTx,
  output logic       rx_gate,
  output logic       busy,
  output logic [7:0] ping_cnt,
  output logic       done,
  output logic       err_timeout,
  output logic       pri_overrun
);

  typedef enum logic [1:0] {S_IDLE, S_TX, S_LISTEN, S_WAIT} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX     = '1;
  localparam logic [CNT_W-1:0] PRI_LAST    = CNT_W'(PRI_CYCLES - 1);
  localparam logic [CNT_W-1:0] LISTEN_LAST = CNT_W'(LISTEN_CYCLES - 1);
  localparam logic [CNT_W-1:0] TX_LAST     = CNT_W'(TX_TIMEOUT - 1);

  state_t           state_q, state_d;
  logic             entx_q, entx_d;
  logic             rx_gate_q, rx_gate_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_timeout_q, err_timeout_d;
  logic             pri_overrun_q, pri_overrun_d;
  logic [7:0]       ping_cnt_q, ping_cnt_d;
  logic [7:0]       num_pings_q, num_pings_d;
  logic [CNT_W-1:0] phase_cnt_q, phase_cnt_d;
  logic [CNT_W-1:0] pri_cnt_q, pri_cnt_d;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_W'(1);
  endfunction

  // phase_cnt times both the TX timeout and the LISTEN window; pri_cnt restarts on every enTx rise
  always_comb begin
    state_d       = state_q;
    entx_d        = entx_q;
    rx_gate_d     = rx_gate_q;
    done_d        = 1'b0;
    err_timeout_d = err_timeout_q;
    pri_overrun_d = pri_overrun_q;
    ping_cnt_d    = ping_cnt_q;
    num_pings_d   = num_pings_q;
    phase_cnt_d   = sat_inc(phase_cnt_q);
    pri_cnt_d     = sat_inc(pri_cnt_q);

    case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          state_d       = S_TX;
          entx_d        = 1'b1;
          num_pings_d   = num_pings;
          ping_cnt_d    = 8'd0;
          err_timeout_d = 1'b0;
          pri_overrun_d = 1'b0;
          phase_cnt_d   = '0;
          pri_cnt_d     = '0;
        end
      end
      S_TX: begin
        if (abort) begin
          state_d = S_IDLE;
          entx_d  = 1'b0;
        end else if (overTx) begin
          state_d     = S_LISTEN;
          entx_d      = 1'b0;
          rx_gate_d   = 1'b1;
          ping_cnt_d  = ping_cnt_q + 8'd1;
          phase_cnt_d = '0;
        end else if (phase_cnt_q == TX_LAST) begin
          state_d       = S_IDLE;
          entx_d        = 1'b0;
          err_timeout_d = 1'b1;
        end
      end
      S_LISTEN: begin
        if (abort) begin
          state_d   = S_IDLE;
          rx_gate_d = 1'b0;
        end else if (phase_cnt_q == LISTEN_LAST) begin
          rx_gate_d = 1'b0;
          if (num_pings_q != 8'd0 && ping_cnt_q == num_pings_q) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else if (pri_cnt_q >= PRI_LAST) begin
            state_d       = S_TX;
            entx_d        = 1'b1;
            pri_overrun_d = 1'b1;
            phase_cnt_d   = '0;
            pri_cnt_d     = '0;
          end else begin
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (pri_cnt_q >= PRI_LAST) begin
          state_d     = S_TX;
          entx_d      = 1'b1;
          phase_cnt_d = '0;
          pri_cnt_d   = '0;
        end
      end
      default: begin
        state_d   = S_IDLE;
        entx_d    = 1'b0;
        rx_gate_d = 1'b0;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk_100) begin
    if (rst) begin
      state_q       <= S_IDLE;
      entx_q        <= 1'b0;
      rx_gate_q     <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      err_timeout_q <= 1'b0;
      pri_overrun_q <= 1'b0;
      ping_cnt_q    <= 8'd0;
      num_pings_q   <= 8'd0;
      phase_cnt_q   <= '0;
      pri_cnt_q     <= '0;
    end else begin
      state_q       <= state_d;
      entx_q        <= entx_d;
      rx_gate_q     <= rx_gate_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      err_timeout_q <= err_timeout_d;
      pri_overrun_q <= pri_overrun_d;
      ping_cnt_q    <= ping_cnt_d;
      num_pings_q   <= num_pings_d;
      phase_cnt_q   <= phase_cnt_d;
      pri_cnt_q     <= pri_cnt_d;
    end
  end

  assign enTx        = entx_q;
  assign rx_gate     = rx_gate_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign err_timeout = err_timeout_q;
  assign pri_overrun = pri_overrun_q;
  assign ping_cnt    = ping_cnt_q;

endmodule

// File: tb/tb_ping_sequencer.sv
// tb/tb_ping_sequencer.sv - self-checking bench for ping_sequencer with a transmitter model
module tb_ping_sequencer;
  localparam int PRI   = 2000;
  localparam int LST   = 800;
  localparam int TMO   = 1024;
  localparam int PRI_B = 600;
  localparam int LST_B = 200;
  localparam int D_FIX = 513;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b1, start = 1'b0, abort = 1'b0;
  logic [7:0] num_pings = 8'd0;
  logic       en_tx, over_tx, rx_gate, busy, done, err_timeout, pri_overrun;
  logic [7:0] ping_cnt;
  logic       model_ovr = 1'b0, inj_ovr = 1'b0;
  assign over_tx = model_ovr | inj_ovr;

  logic       start_b = 1'b0, abort_b = 1'b0;
  logic [7:0] num_pings_b = 8'd0;
  logic       en_tx_b, over_tx_b = 1'b0, rx_gate_b, busy_b, done_b, err_timeout_b, pri_overrun_b;
  logic [7:0] ping_cnt_b;

  ping_sequencer #(.CNT_W(20), .PRI_CYCLES(PRI), .LISTEN_CYCLES(LST), .TX_TIMEOUT(TMO)) dut (
    .clk_100(clk), .rst(rst), .start(start), .abort(abort), .num_pings(num_pings),
    .enTx(en_tx), .overTx(over_tx), .rx_gate(rx_gate), .busy(busy), .ping_cnt(ping_cnt),
    .done(done), .err_timeout(err_timeout), .pri_overrun(pri_overrun));

  ping_sequencer #(.CNT_W(20), .PRI_CYCLES(PRI_B), .LISTEN_CYCLES(LST_B), .TX_TIMEOUT(TMO)) dut_b (
    .clk_100(clk), .rst(rst), .start(start_b), .abort(abort_b), .num_pings(num_pings_b),
    .enTx(en_tx_b), .overTx(over_tx_b), .rx_gate(rx_gate_b), .busy(busy_b), .ping_cnt(ping_cnt_b),
    .done(done_b), .err_timeout(err_timeout_b), .pri_overrun(pri_overrun_b));

  int cyc = 0;
  always @(posedge clk) cyc++;

  // Transmitter model: overTx strobes in the tx_dly-th cycle of enTx, so enTx stays high tx_dly cycles
  bit tx_en = 1'b1, rand_dly = 1'b0;
  int tx_age = 0, tx_dly = D_FIX;
  int dly_q[$];
  always @(negedge clk) begin
    if (en_tx) begin
      if (tx_age == 0) begin
        tx_dly = rand_dly ? int'($urandom_range(900, 1)) : D_FIX;
        dly_q.push_back(tx_dly);
      end
      tx_age++;
    end else begin
      tx_age = 0;
    end
    model_ovr = tx_en && en_tx && (tx_age == tx_dly);
  end

  int age_b = 0;
  always @(negedge clk) begin
    if (en_tx_b) age_b++;
    else age_b = 0;
    over_tx_b = (age_b == D_FIX);
  end

  // Event recorder for the main instance
  bit en_prev = 1'b0, rx_prev = 1'b0;
  int en_len = 0, rx_len = 0;
  int rise_q[$], fall_q[$], en_len_q[$], rx_rise_q[$], rx_len_q[$], done_q[$];
  always @(negedge clk) begin
    if (en_tx && !en_prev) rise_q.push_back(cyc);
    if (!en_tx && en_prev) begin
      fall_q.push_back(cyc);
      en_len_q.push_back(en_len);
      en_len = 0;
    end
    if (en_tx) en_len++;
    if (rx_gate && !rx_prev) rx_rise_q.push_back(cyc);
    if (!rx_gate && rx_prev) begin
      rx_len_q.push_back(rx_len);
      rx_len = 0;
    end
    if (rx_gate) rx_len++;
    if (done) done_q.push_back(cyc);
    en_prev = en_tx;
    rx_prev = rx_gate;
  end

  int errors = 0, checks = 0;
  int start_cyc = 0;

  task automatic check(input string tag, input longint obs, input longint exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_mon();
    rise_q.delete(); fall_q.delete(); en_len_q.delete();
    rx_rise_q.delete(); rx_len_q.delete(); done_q.delete(); dly_q.delete();
  endtask

  task automatic pulse_start(input int n);
    num_pings = 8'(n);
    start     = 1'b1;
    start_cyc = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int i = 0;
    while (busy && i < budget) begin
      @(negedge clk);
      i++;
    end
    check(tag, busy, 0);
    step(2);
  endtask

  task automatic wait_rx_done(input string tag, input int n, input int budget);
    int i = 0;
    while (rx_len_q.size() < n && i < budget) begin
      @(negedge clk);
      i++;
    end
    check(tag, rx_len_q.size() >= n, 1);
  endtask

  // Expected schedule: rises PRI apart, enTx high for the chirp length, rx_gate right after for LST
  task automatic check_sequence(input string tag, input int n);
    check({tag, "_rises"}, rise_q.size(), n);
    check({tag, "_first_rise"}, rise_q[0], start_cyc + 1);
    for (int k = 1; k < n; k++) check({tag, "_pri"}, rise_q[k] - rise_q[k-1], PRI);
    for (int k = 0; k < n; k++) begin
      check({tag, "_en_len"}, en_len_q[k], dly_q[k]);
      check({tag, "_rx_len"}, rx_len_q[k], LST);
      check({tag, "_rx_after_tx"}, rx_rise_q[k], fall_q[k]);
    end
    check({tag, "_done_cnt"}, done_q.size(), 1);
    check({tag, "_done_cyc"}, done_q[0], rise_q[n-1] + dly_q[n-1] + LST);
    check({tag, "_ping_cnt"}, ping_cnt, n);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int n, i, r0, hi;

    step(5);
    check("rst_flags", {en_tx, rx_gate, busy, done, err_timeout, pri_overrun}, 6'b0);
    check("rst_ping_cnt", ping_cnt, 0);
    check("rst_flags_b", {en_tx_b, rx_gate_b, busy_b, done_b, err_timeout_b, pri_overrun_b}, 6'b0);
    rst = 1'b0;
    step(3);

    // three pings with a fixed chirp length
    clear_mon();
    pulse_start(3);
    check("t1_busy", busy, 1);
    wait_idle("t1_idle", 4 * PRI);
    check_sequence("t1", 3);
    check("t1_ovr", pri_overrun, 0);

    // random ping count and random chirp lengths
    clear_mon();
    rand_dly = 1'b1;
    n = int'($urandom_range(4, 2));
    pulse_start(n);
    wait_idle("t1r_idle", (n + 1) * PRI);
    rand_dly = 1'b0;
    check("t1r_dlys", dly_q.size(), n);
    check_sequence("t1r", n);

    // continuous mode, abort during WAIT after five pings
    clear_mon();
    pulse_start(0);
    wait_rx_done("t2_five", 5, 6 * PRI);
    step(int'($urandom_range(300, 50)));
    check("t2_wait_state", {busy, en_tx, rx_gate}, 3'b100);
    abort = 1'b1;
    step(1);
    abort = 1'b0;
    check("t2_abort_outs", {en_tx, rx_gate, busy}, 3'b000);
    check("t2_ping_cnt", ping_cnt, 5);
    step(PRI);
    check("t2_no_done", done_q.size(), 0);
    check("t2_no_more_tx", rise_q.size(), 5);

    // transmitter never completes: TX timeout
    clear_mon();
    tx_en = 1'b0;
    pulse_start(1);
    wait_idle("t3_idle", TMO + 50);
    check("t3_en_len", en_len_q[0], TMO);
    check("t3_err", err_timeout, 1);
    check("t3_no_done", done_q.size(), 0);
    check("t3_no_rx", rx_rise_q.size(), 0);
    tx_en = 1'b1;
    clear_mon();
    pulse_start(1);
    check("t3_err_clr", err_timeout, 0);
    wait_idle("t3b_idle", 2 * PRI);
    check("t3b_done", done_q.size(), 1);

    // stray start in LISTEN and stray overTx in WAIT are ignored
    clear_mon();
    pulse_start(2);
    i = 0;
    while (!rx_gate && i < PRI) begin step(1); i++; end
    step(100);
    num_pings = 8'd7;
    start = 1'b1;
    step(1);
    start = 1'b0;
    wait_rx_done("t4_listen", 1, PRI);
    step(100);
    check("t4_in_wait", {busy, en_tx, rx_gate}, 3'b100);
    inj_ovr = 1'b1;
    step(1);
    inj_ovr = 1'b0;
    wait_idle("t4_idle", 3 * PRI);
    check_sequence("t4", 2);

    // abort and overTx together in TX of the second ping
    clear_mon();
    pulse_start(2);
    i = 0;
    while (rise_q.size() < 2 && i < 2 * PRI) begin step(1); i++; end
    tx_en = 1'b0;
    step(20);
    abort   = 1'b1;
    inj_ovr = 1'b1;
    step(1);
    abort   = 1'b0;
    inj_ovr = 1'b0;
    check("t5_outs", {en_tx, rx_gate, busy}, 3'b000);
    check("t5_ping_cnt", ping_cnt, 1);
    step(50);
    check("t5_no_rx", rx_rise_q.size(), 1);
    check("t5_no_done", done_q.size(), 0);
    tx_en = 1'b1;

    // reset mid-sequence
    clear_mon();
    pulse_start(3);
    step(1000);
    check("t7_in_listen", rx_gate, 1);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    check("t7_rst_flags", {en_tx, rx_gate, busy, done, err_timeout, pri_overrun}, 6'b0);
    check("t7_rst_ping", ping_cnt, 0);
    step(3);

    // short PRI: LISTEN ends after PRI expiry
    num_pings_b = 8'd2;
    start_b = 1'b1;
    step(1);
    start_b = 1'b0;
    r0 = cyc;
    check("t6_en", en_tx_b, 1);
    check("t6_ovr_init", pri_overrun_b, 0);
    i = 0;
    while (!rx_gate_b && i < 2000) begin step(1); i++; end
    hi = 0;
    while (rx_gate_b && hi < 2000) begin step(1); hi++; end
    check("t6_rx_len", hi, LST_B);
    check("t6_tx_next", en_tx_b, 1);
    check("t6_ovr", pri_overrun_b, 1);
    check("t6_rise_gap", cyc - r0, D_FIX + LST_B);
    i = 0;
    while (busy_b && i < 4000) begin step(1); i++; end
    check("t6_done", {busy_b, done_b}, 2'b01);
    check("t6_ping_cnt", ping_cnt_b, 2);
    check("t6_ovr_sticky", pri_overrun_b, 1);
    start_b = 1'b1;
    step(1);
    start_b = 1'b0;
    check("t6_ovr_clr", pri_overrun_b, 0);
    abort_b = 1'b1;
    step(1);
    abort_b = 1'b0;
    check("t6_abort", {en_tx_b, busy_b}, 2'b00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
